instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the word-index width; instruction memory depth is 2**ADDR_W words.
REQ-002 Parameter HOLD_CYC, default 4, sets the quiet cycles between the last memory write and initiate rising (minimum 1).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first loaded word.
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE.
REQ-007 len  input  ADDR_W+1  number of words to load, sampled on an accepted start.
REQ-008 in_valid  input  1  upstream word available.
REQ-009 in_data  input  32  instruction word.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_addr  output  32  byte address, word-aligned.
REQ-013 mem_wdata  output  32  write data.
REQ-014 initiate  output  1  run enable to the DataPath; stays high once raised.
REQ-015 busy  output  1  high in LOAD or HOLD.
REQ-016 len_err  output  1  sticky flag set by start with len > 2**ADDR_W; cleared by the next accepted start.

Function
REQ-017 States: IDLE, LOAD, HOLD, RUN.
REQ-018 IDLE -> LOAD on start with 0 < len <= 2**ADDR_W; IDLE -> HOLD on start with len == 0; IDLE stays IDLE and sets len_err on start with len > 2**ADDR_W.
REQ-019 in_ready = 1 only in LOAD while the accepted-word count is below len; a transfer is in_valid && in_ready in the same cycle.
REQ-020 Each transfer registers one write: mem_we = 1 in the following cycle, with mem_wdata = the accepted word and mem_addr = BASE_ADDR + 4*index, where index counts 0..len-1.
REQ-021 mem_we is low in every cycle that does not follow a transfer; in_valid gaps insert no writes and lose no data.
REQ-022 On the transfer of word len-1, LOAD -> HOLD on the next edge and in_ready drops on that edge; the final mem_we coincides with the first HOLD cycle.
REQ-023 HOLD lasts exactly HOLD_CYC cycles, counted from the first HOLD cycle, then HOLD -> RUN.
REQ-024 In RUN, initiate = 1 and all other outputs are inactive; RUN is left only by reset.
REQ-025 start outside IDLE is ignored, with no effect on counters, len, or len_err.
REQ-026 len == 2**ADDR_W loads every location; the index never wraps past 2**ADDR_W-1.
REQ-027 initiate is registered and glitch-free; it is 0 in IDLE, LOAD and HOLD.

Reset
REQ-028 When reset = 1 at a rising edge, the next state is IDLE and outputs are: initiate=0, in_ready=0, mem_we=0, busy=0, len_err=0, mem_addr=BASE_ADDR, mem_wdata=0, all counters=0.
REQ-029 Reset mid-LOAD or mid-HOLD aborts the load with no further mem_we; a pending write registered in the last pre-reset cycle is discarded.
REQ-030 reset takes priority over start and over any transfer in the same cycle.

Structure
REQ-031 The state encoding constants (IDLE/LOAD/HOLD/RUN) and the instruction word width (32) live in the shared MIPS definitions include used by the DataPath.
REQ-032 A single sub-module, hold_counter (loadable down-counter with a zero flag), times the HOLD state; everything else is flat.
REQ-033 The memory write port (mem_we/mem_addr/mem_wdata) matches the instruction memory's write-port timing so that instr_loader connects directly upstream of DataPath.

Verification
REQ-034 Reset held 2 cycles, then start with len=3 and words 0x20080005, 0x20090007, 0x01095020 streamed back-to-back -> writes at 0x0, 0x4, 0x8 on consecutive cycles, then initiate rises exactly 4 cycles after the first HOLD cycle.
REQ-035 len=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, in order, with no extra mem_we.
REQ-036 start with len=0 -> no mem_we, busy for 4 cycles, then initiate=1.
REQ-037 start with len=2**ADDR_W+1 -> len_err=1, state remains IDLE, initiate=0; a following start with len=1 clears len_err and loads 1 word.
REQ-038 reset asserted after the 2nd of 3 transfers -> no 3rd write, initiate=0, a fresh load from address 0x0 succeeds afterwards.
REQ-039 start pulsed during LOAD and during RUN -> no change in index, addresses, or initiate.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// the instruction word width used by the DataPath.
package instr_loader_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/instr_loader_hold_counter.sv
// Loadable down-counter with a zero flag; times the quiet period between
// the last instruction write and the DataPath run enable.
module hold_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Saturates at zero so a long stay in the enabled state cannot wrap.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/instr_loader.sv
// Streams instruction words into the instruction memory write port, waits a
// fixed quiet period, then raises a sticky run enable for the DataPath.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          HOLD_CYC  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               initiate,
  output logic               busy,
  output logic               len_err
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_t state, state_next;

  logic [ADDR_W:0]    len_q;
  logic [ADDR_W:0]    count;
  logic               mem_we_q;
  logic [31:0]        mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic               len_err_q;
  logic               initiate_q;

  logic xfer;
  logic last_xfer;
  logic start_ok;
  logic start_bad;
  logic hold_load;
  logic hold_zero;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    in_ready   = (state == LOAD) && (count < len_q);
    xfer       = in_valid && in_ready;
    last_xfer  = xfer && (count == (len_q - ONE));
    start_ok   = (state == IDLE) && start && (len <= DEPTH);
    start_bad  = (state == IDLE) && start && (len > DEPTH);
    busy       = (state == LOAD) || (state == HOLD);
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (len == '0) begin
            state_next = HOLD;
            hold_load  = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_xfer) begin
          state_next = HOLD;
          hold_load  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_zero)
          state_next = RUN;
      end
      RUN: state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Loaded with HOLD_CYC-1 on HOLD entry, so the counter reads zero in the
  // last HOLD cycle and the FSM leaves after exactly HOLD_CYC cycles.
  hold_counter #(
    .W(HW)
  ) u_hold_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (HW'(HOLD_CYC - 1)),
    .en       (state == HOLD),
    .zero     (hold_zero)
  );

  // Each accepted word becomes a write one cycle later; the address comes
  // from the pre-increment count, which never exceeds the top word index.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      count       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      len_err_q   <= 1'b0;
      initiate_q  <= 1'b0;
    end else begin
      mem_we_q   <= xfer;
      initiate_q <= (state_next == RUN);
      if (xfer) begin
        mem_wdata_q <= in_data;
        mem_addr_q  <= BASE_ADDR + (32'(count[ADDR_W-1:0]) << 2);
        count       <= count + ONE;
      end
      if (start_ok) begin
        len_q     <= len;
        count     <= '0;
        len_err_q <= 1'b0;
      end else if (start_bad) begin
        len_err_q <= 1'b1;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign len_err   = len_err_q;
  assign initiate  = initiate_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a per-cycle vector table for the basic
// load, plus hand-written sequences for gaps, empty loads, errors and reset.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int ADDR_W = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W:0]    len = '0;
  logic               in_valid = 1'b0;
  logic [INSTR_W-1:0] in_data = '0;
  logic               in_ready;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               initiate;
  logic               busy;
  logic               len_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  typedef struct {
    logic        st;
    logic [2:0]  ln;
    logic        vl;
    logic [31:0] dt;
    logic        rdy;
    logic        we;
    logic        bsy;
    logic        ini;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[9];

  instr_loader #(
    .ADDR_W    (ADDR_W),
    .HOLD_CYC  (4),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .initiate  (initiate),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, sample #1 later and log writes.
  task automatic applyStimulus(input logic s, input logic [2:0] l,
                               input logic v, input logic [31:0] d);
    @(negedge clk);
    start    = s;
    len      = l;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  initial begin
    // Basic back-to-back load of three words, then a start ignored in RUN.
    vecs[0] = '{1'b1, 3'd3, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 3'd0, 1'b1, 32'h20080005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20080005};
    vecs[2] = '{1'b0, 3'd0, 1'b1, 32'h20090007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h20090007};
    vecs[3] = '{1'b0, 3'd0, 1'b1, 32'h01095020, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h01095020};
    vecs[4] = '{1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b1, 3'd2, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_initiate", 32'(initiate), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ln, vecs[i].vl, vecs[i].dt);
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      checkOutput($sformatf("vec%0d_initiate", i), 32'(initiate), 32'(vecs[i].ini));
      checkOutput($sformatf("vec%0d_len_err", i), 32'(len_err), 32'(vecs[i].err));
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].addr);
        checkOutput($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      end
    end

    // in_valid gaps: only words offered with in_valid high are written.
    doReset();
    applyStimulus(1'b1, 3'd3, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 3'd0, (i == 0 || i == 3 || i == 5), 32'h1000_0000 + 32'(i));
    idle(5);
    checkOutput("gap_write_count", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      checkOutput("gap_addr0", wr_addr[0], 32'h0);
      checkOutput("gap_data0", wr_data[0], 32'h1000_0000);
      checkOutput("gap_addr1", wr_addr[1], 32'h4);
      checkOutput("gap_data1", wr_data[1], 32'h1000_0003);
      checkOutput("gap_addr2", wr_addr[2], 32'h8);
      checkOutput("gap_data2", wr_data[2], 32'h1000_0005);
    end
    checkOutput("gap_initiate", 32'(initiate), 32'd1);

    // Empty load goes straight to HOLD for four cycles.
    doReset();
    applyStimulus(1'b1, 3'd0, 1'b0, 32'h0);
    checkOutput("len0_busy_c1", 32'(busy), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b1, 32'hABCD0000);
      checkOutput($sformatf("len0_busy_c%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("len0_initiate_c%0d", i), 32'(initiate), 32'd0);
    end
    idle(1);
    checkOutput("len0_busy_run", 32'(busy), 32'd0);
    checkOutput("len0_initiate_run", 32'(initiate), 32'd1);
    checkOutput("len0_write_count", 32'(wr_addr.size()), 32'd0);

    // Oversized length flags an error and stays idle; a valid start clears it.
    doReset();
    applyStimulus(1'b1, 3'd5, 1'b1, 32'h0);
    checkOutput("err_len_err", 32'(len_err), 32'd1);
    checkOutput("err_busy", 32'(busy), 32'd0);
    checkOutput("err_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    checkOutput("err_sticky", 32'(len_err), 32'd1);
    checkOutput("err_initiate", 32'(initiate), 32'd0);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'h0);
    checkOutput("err_cleared", 32'(len_err), 32'd0);
    checkOutput("err_load_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hDEADBEEF);
    checkOutput("err_one_we", 32'(mem_we), 32'd1);
    checkOutput("err_one_addr", mem_addr, 32'h0);
    checkOutput("err_one_data", mem_wdata, 32'hDEADBEEF);
    checkOutput("err_one_ready", 32'(in_ready), 32'd0);

    // Reset after the second of three transfers, with a third word offered.
    doReset();
    applyStimulus(1'b1, 3'd3, 1'b0, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hA0000000);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hA0000001);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA0000002;
    @(posedge clk);
    #1;
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'h0);
    checkOutput("abort_initiate", 32'(initiate), 32'd0);
    checkOutput("abort_write_count", 32'(wr_addr.size()), 32'd2);
    doReset();
    applyStimulus(1'b1, 3'd1, 1'b0, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'h5555AAAA);
    checkOutput("reload_we", 32'(mem_we), 32'd1);
    checkOutput("reload_addr", mem_addr, 32'h0);
    checkOutput("reload_data", mem_wdata, 32'h5555AAAA);

    // Full-depth load with a start pulse mid-LOAD that must be ignored.
    doReset();
    applyStimulus(1'b1, 3'd4, 1'b0, 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hC0000000);
    applyStimulus(1'b1, 3'd1, 1'b1, 32'hC0000001);
    checkOutput("midstart_addr", mem_addr, 32'h4);
    checkOutput("midstart_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hC0000002);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hC0000003);
    checkOutput("full_last_addr", mem_addr, 32'hC);
    checkOutput("full_last_data", mem_wdata, 32'hC0000003);
    checkOutput("full_ready_drop", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1, 32'hC0000004);
    checkOutput("full_no_extra_we", 32'(mem_we), 32'd0);
    checkOutput("full_write_count", 32'(wr_addr.size()), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
